pipe_stage_skid_reg: RTL
========================

# pipe_stage_skid_reg

Parametrised pipeline stage register for the RISC-V core: carries one control bundle and one datapath word between two pipeline stages. It uses a valid/ready handshake, a 2-entry skid buffer, synchronous flush (bubble insertion) and a saturating stall counter. It sits at the stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces per-stage hand-written registers. It adds stall and flush capability that the plain registers lack.

## Interface
- CTRL_W, 24, width of control bundle (load/RF-enable/RAM/ALU-op/etc. flags packed)
- DATA_W, 32, width of datapath word (instruction, ALU result, PC, ...)
- CNT_W, 16, width of stall performance counter
- clk  in  1  clock; all state changes on rising edge
- Reset  in  1  reset: one clock; reset is asynchronous and active-low
- flush  in  1  synchronous flush; empties stage and skid on next edge
- in_valid  in  1  upstream has a valid entry
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data word
- out_valid  out  1  stage holds a valid entry
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bundle; forced all-zero whenever out_valid=0
- out_data  out  DATA_W  data word; holds last loaded value when out_valid=0
- stat_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main entry M (valid, ctrl, data) drives outputs; skid entry S (valid, ctrl, data) catches data accepted while M is blocked.
- Accept: in_fire = in_valid & in_ready; in_ready = !S.valid. Emit: out_fire = out_valid & out_ready; out_valid = M.valid.
- M update (no flush):
  - M empty or out_fire, S valid: M <= S, S.valid <= 0 (S drains first, order preserved).
  - M empty or out_fire, S empty, in_fire: M <= input.
  - M empty or out_fire, nothing available: M.valid <= 0.
  - M full, !out_ready, in_fire: S <= input (S is empty by construction since in_ready=1).
- Simultaneous S drain and in_fire cannot occur (in_ready=0 while S valid).
- Flush: M.valid, S.valid <= 0. An in_fire in the flush cycle is discarded. An out_fire in the flush cycle completes normally (downstream already sampled it). Data registers are not cleared by flush.
- Bubble rule: out_ctrl = M.valid ? M.ctrl : 0, so a bubble never asserts RF/RAM enables downstream.
- stall_cnt: increments when out_valid & !out_ready. Saturates at 2^CNT_W-1 (no wrap). stat_clr has priority over increment. Counting continues during a flush cycle if the condition holds.
- Reset asserted (Reset=0), asynchronous:
  - M.valid = S.valid = 0, all ctrl/data = 0, stall_cnt = 0.
  - Hence out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
  - Mid-operation reset discards both entries immediately.
- Deassertion is synchronised externally. The first edge after deassertion behaves as a normal cycle.

## Timing
- Latency: in_fire at edge N, so out_valid=1 with that entry after edge N (visible in cycle N+1). This is one cycle, the same as a plain register.
- Throughput: 1 entry/cycle sustained with out_ready=1.
- Back-pressure: one extra entry accepted after out_ready drops. in_ready falls one cycle after S fills and rises the cycle after S drains.
- Full (M and S valid) to empty takes two out_fire cycles.
- in_ready, out_valid, out_data and stall_cnt are pure register outputs. out_ctrl has only an AND gate after the register.

## Test plan
- Reset: hold Reset=0 mid-stream with M and S full -> immediately out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, push data 0x00000001..0x00000008 on consecutive cycles -> out_data shows the same sequence one cycle later, no gaps, in_ready stays 1.
- Skid: M holds 0xA, out_ready=0, push 0xB -> in_ready=0 next cycle. Raise out_ready -> outputs 0xA then 0xB in order. in_ready returns to 1 the cycle after 0xB moves to M.
- Flush with accept: M=0xA, S=0xB, flush=1 with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1. 0xC never appears.
- Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays. stat_clr=1 with stall still present -> next value 0.
- Bubble gating: in_ctrl=all-ones, let entry drain with no new input -> out_valid=0 and out_ctrl=0, out_data retains last value.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready pipeline register with 2-entry skid, flush and stall counter
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              stat_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire, m_take, stall;

  assign in_ready_o  = !s_valid_q;
  assign out_valid_o = m_valid_q;
  assign out_ctrl_o  = m_valid_q ? m_ctrl_q : '0;
  assign out_data_o  = m_data_q;
  assign stall_cnt_o = cnt_q;
  assign in_fire     = in_valid_i & !s_valid_q;
  assign m_take      = !m_valid_q | out_ready_i;
  assign stall       = m_valid_q & !out_ready_i;

  // Next state: skid drains into main before new input; flush drops valids but keeps data.
  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_take) begin
      m_valid_d = s_valid_q | in_fire;
      m_ctrl_d  = s_valid_q ? s_ctrl_q : in_fire ? in_ctrl_i : m_ctrl_q;
      m_data_d  = s_valid_q ? s_data_q : in_fire ? in_data_i : m_data_q;
      s_valid_d = 1'b0;
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = in_ctrl_i;
      s_data_d  = in_data_i;
    end
    cnt_d = stat_clr_i ? '0 : (stall && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
  end

  // State registers; reset empties both entries and clears all payload and the counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule
